// File: rtl/spi_xip_pkg.sv
// Shared constants for the SPI execute-in-place bridge: spi_top_apb register map,
// the XIP READ control word and the sequencing FSM states.
package spi_xip_pkg;

    localparam logic [31:0] REG_RX0  = 32'h0000_0000;
    localparam logic [31:0] REG_TX1  = 32'h0000_0004;
    localparam logic [31:0] REG_CTRL = 32'h0000_0010;
    localparam logic [31:0] REG_DIV  = 32'h0000_0014;
    localparam logic [31:0] REG_SS   = 32'h0000_0018;

    // ASS | Tx_NEG | GO | CHAR_LEN=64: 8-bit cmd + 24-bit addr out, 32 data bits back
    localparam logic [31:0] CTRL_XIP_READ  = 32'h0000_2540;
    localparam int          GO_BIT         = 8;
    localparam logic [7:0]  FLASH_CMD_READ = 8'h03;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TX1,
        S_DIV,
        S_SS,
        S_CTRL,
        S_POLL,
        S_RX,
        S_SSCLR,
        S_RESP
    } xip_state_e;

    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/spi_xip_apb_master.sv
// Single-transfer APB master. While start_i is held it runs setup then access phases;
// done_o pulses on the completing access cycle, after which the next request starts with setup.
module spi_xip_apb_master (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        write_i,
    output logic [31:0] paddr_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    output logic [3:0]  pstrb_o,
    input  logic        pready_i,
    input  logic [31:0] prdata_i,
    input  logic        pslverr_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic access_q, access_d;

    always_comb begin
        access_d = 1'b0;
        if (start_i) begin
            access_d = access_q ? !pready_i : 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            access_q <= 1'b0;
        end else begin
            access_q <= access_d;
        end
    end

    assign psel_o    = start_i;
    assign penable_o = start_i & access_q;
    assign paddr_o   = start_i ? addr_i : '0;
    assign pwrite_o  = start_i & write_i;
    assign pwdata_o  = (start_i & write_i) ? wdata_i : '0;
    assign pstrb_o   = (start_i & write_i) ? 4'hf : 4'h0;
    assign done_o    = start_i & access_q & pready_i;
    assign err_o     = done_o & pslverr_i;
    assign rdata_o   = prdata_i;

endmodule

// File: rtl/spi_xip_ctrl.sv
// XIP bridge: upstream reads in the flash window become one SPI flash READ sequenced through
// spi_top_apb; other accesses pass through. Define SPI_XIP_LINEBUF_EN for a one-word read buffer.
module spi_xip_ctrl
    import spi_xip_pkg::*;
#(
    parameter logic [31:0] flash_addr_start = 32'h3000_0000,
    parameter logic [31:0] flash_addr_end   = 32'h3fff_ffff,
    parameter logic [15:0] spi_div          = 16'h0001,
    parameter logic [7:0]  flash_ss         = 8'h01
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    output logic [31:0] out_paddr,
    output logic        out_psel,
    output logic        out_penable,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr
);

    xip_state_e  state_q, state_d;
    logic [21:0] waddr_q, waddr_d;
    logic [31:0] rx_q, rx_d;
    logic        err_q, err_d;

    logic        in_win;
    logic        lb_hit;
    logic [31:0] lb_data;

    logic        m_start, m_write, m_done, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [31:0] m_paddr, m_pwdata;
    logic        m_psel, m_penable, m_pwrite;
    logic [3:0]  m_pstrb;

    assign in_win = (in_paddr >= flash_addr_start) && (in_paddr <= flash_addr_end);

`ifdef SPI_XIP_LINEBUF_EN
    logic        lb_vld_q, lb_vld_d;
    logic [21:0] lb_addr_q, lb_addr_d;
    logic [31:0] lb_data_q, lb_data_d;

    always_comb begin
        lb_vld_d  = lb_vld_q;
        lb_addr_d = lb_addr_q;
        lb_data_d = lb_data_q;
        if (state_q == S_RESP) begin
            if (err_q) begin
                lb_vld_d = 1'b0;
            end else begin
                lb_vld_d  = 1'b1;
                lb_addr_d = waddr_q;
                lb_data_d = rx_q;
            end
        end
        // Rewriting CTRL or SS behind our back may leave the flash in an unknown state
        if (state_q == S_IDLE && in_psel && in_pwrite && !in_win &&
            (in_paddr[7:0] == REG_CTRL[7:0] || in_paddr[7:0] == REG_SS[7:0])) begin
            lb_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lb_vld_q  <= 1'b0;
            lb_addr_q <= '0;
            lb_data_q <= '0;
        end else begin
            lb_vld_q  <= lb_vld_d;
            lb_addr_q <= lb_addr_d;
            lb_data_q <= lb_data_d;
        end
    end

    assign lb_hit  = lb_vld_q && (lb_addr_q == in_paddr[23:2]);
    assign lb_data = lb_data_q;
`else
    assign lb_hit  = 1'b0;
    assign lb_data = '0;
`endif

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        rx_d    = rx_q;
        err_d   = err_q;
        m_start = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_write = 1'b0;
        case (state_q)
            S_IDLE: begin
                waddr_d = in_paddr[23:2];
                err_d   = 1'b0;
                if (in_psel && in_win && !in_pwrite) begin
                    if (lb_hit) begin
                        rx_d    = lb_data;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_TX1;
                    end
                end
            end
            S_TX1: begin
                m_start = 1'b1;
                m_addr  = REG_TX1;
                m_wdata = {FLASH_CMD_READ, waddr_q, 2'b00};
                m_write = 1'b1;
                if (m_done) state_d = S_DIV;
            end
            S_DIV: begin
                m_start = 1'b1;
                m_addr  = REG_DIV;
                m_wdata = {16'h0000, spi_div};
                m_write = 1'b1;
                if (m_done) state_d = S_SS;
            end
            S_SS: begin
                m_start = 1'b1;
                m_addr  = REG_SS;
                m_wdata = {24'h00_0000, flash_ss};
                m_write = 1'b1;
                if (m_done) state_d = S_CTRL;
            end
            S_CTRL: begin
                m_start = 1'b1;
                m_addr  = REG_CTRL;
                m_wdata = CTRL_XIP_READ;
                m_write = 1'b1;
                if (m_done) state_d = S_POLL;
            end
            S_POLL: begin
                m_start = 1'b1;
                m_addr  = REG_CTRL;
                if (m_done && !m_rdata[GO_BIT]) state_d = S_RX;
            end
            S_RX: begin
                m_start = 1'b1;
                m_addr  = REG_RX0;
                if (m_done) begin
                    rx_d    = m_rdata;
                    state_d = S_SSCLR;
                end
            end
            S_SSCLR: begin
                m_start = 1'b1;
                m_addr  = REG_SS;
                m_write = 1'b1;
                if (m_done) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A slave error skips the remaining steps but still releases chip select
        if (m_err) begin
            err_d = 1'b1;
            if (state_q != S_SSCLR) state_d = S_SSCLR;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            waddr_q <= '0;
            rx_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            rx_q    <= rx_d;
            err_q   <= err_d;
        end
    end

    spi_xip_apb_master u_mst (
        .clock     (clock),
        .reset     (reset),
        .start_i   (m_start),
        .addr_i    (m_addr),
        .wdata_i   (m_wdata),
        .write_i   (m_write),
        .paddr_o   (m_paddr),
        .psel_o    (m_psel),
        .penable_o (m_penable),
        .pwrite_o  (m_pwrite),
        .pwdata_o  (m_pwdata),
        .pstrb_o   (m_pstrb),
        .pready_i  (out_pready),
        .prdata_i  (out_prdata),
        .pslverr_i (out_pslverr),
        .done_o    (m_done),
        .rdata_o   (m_rdata),
        .err_o     (m_err)
    );

    always_comb begin
        out_paddr   = '0;
        out_psel    = 1'b0;
        out_penable = 1'b0;
        out_pwrite  = 1'b0;
        out_pwdata  = '0;
        out_pstrb   = 4'h0;
        in_pready   = 1'b0;
        in_prdata   = '0;
        in_pslverr  = 1'b0;
        if (reset) begin
            // everything stays 0 while reset is asserted
        end else if (state_q == S_IDLE) begin
            if (in_psel && !in_win) begin
                out_paddr   = in_paddr;
                out_psel    = in_psel;
                out_penable = in_penable;
                out_pwrite  = in_pwrite;
                out_pwdata  = in_pwdata;
                out_pstrb   = in_pstrb;
                in_pready   = out_pready;
                in_prdata   = out_prdata;
                in_pslverr  = out_pslverr;
            end else if (in_psel && in_penable && in_pwrite) begin
                in_pready  = 1'b1;
                in_pslverr = 1'b1;
            end
        end else begin
            out_paddr   = m_paddr;
            out_psel    = m_psel;
            out_penable = m_penable;
            out_pwrite  = m_pwrite;
            out_pwdata  = m_pwdata;
            out_pstrb   = m_pstrb;
            if (state_q == S_RESP) begin
                in_pready  = 1'b1;
                in_pslverr = err_q;
                in_prdata  = err_q ? 32'h0 : bswap32(rx_q);
            end
        end
    end

endmodule

// File: tb/tb_spi_xip_ctrl.sv
// Directed bench for spi_xip_ctrl with a behavioural spi_top_apb + flash model on the downstream side.
module tb_spi_xip_ctrl;
    import spi_xip_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] in_paddr, in_pwdata, in_prdata;
    logic        in_psel, in_penable, in_pwrite, in_pready, in_pslverr;
    logic [3:0]  in_pstrb;
    logic [31:0] out_paddr, out_pwdata, out_prdata;
    logic        out_psel, out_penable, out_pwrite, out_pready, out_pslverr;
    logic [3:0]  out_pstrb;

    spi_xip_ctrl dut (
        .clock(clock), .reset(reset),
        .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable), .in_pwrite(in_pwrite),
        .in_pwdata(in_pwdata), .in_pstrb(in_pstrb), .in_pready(in_pready), .in_prdata(in_prdata),
        .in_pslverr(in_pslverr),
        .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
        .out_pwrite(out_pwrite), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb),
        .out_pready(out_pready), .out_prdata(out_prdata), .out_pslverr(out_pslverr)
    );

    always #5 clock = ~clock;

    // downstream model: SPI master registers + 64-byte flash image
    logic [7:0]  mem [0:63];
    bit          dn_ready;
    logic [31:0] err_addr;
    int          go_until;
    logic [31:0] tx1_q = '0, ctrl_v = '0, div_v = '0, ss_last = '0, last_paddr = '0, prev_addr = '0;
    int          ctrl_rd = 0, ctrl_wr = 0, ss_wr = 0, xfers = 0, setups = 0, strb_bad = 0, hold_viol = 0;
    bit          hold_chk = 1'b0;

    always_comb begin
        out_pready  = dn_ready;
        out_pslverr = out_psel && (out_paddr == err_addr);
        case (out_paddr)
            32'h00:  out_prdata = {mem[tx1_q[5:0]], mem[tx1_q[5:0] + 6'd1],
                                   mem[tx1_q[5:0] + 6'd2], mem[tx1_q[5:0] + 6'd3]};
            32'h10:  out_prdata = (ctrl_rd < go_until) ? 32'h0000_0100 : 32'h0;
            default: out_prdata = out_paddr ^ 32'hDEAD_BEEF;
        endcase
    end

    always @(posedge clock) begin
        if (out_psel && !out_penable) setups <= setups + 1;
        if (out_psel && out_pwrite && out_paddr < 32'h20 && out_pstrb != 4'hf) strb_bad <= strb_bad + 1;
        if (out_psel && out_penable && out_pready) begin
            xfers      <= xfers + 1;
            last_paddr <= out_paddr;
            if (out_pwrite) begin
                case (out_paddr)
                    32'h04: tx1_q <= out_pwdata;
                    32'h10: begin ctrl_v <= out_pwdata; ctrl_wr <= ctrl_wr + 1; end
                    32'h14: div_v <= out_pwdata;
                    32'h18: begin ss_last <= out_pwdata; ss_wr <= ss_wr + 1; end
                    default: ;
                endcase
            end else if (out_paddr == 32'h10) begin
                ctrl_rd <= ctrl_rd + 1;
            end
        end
        hold_chk  <= out_psel && out_penable && !out_pready;
        prev_addr <= out_paddr;
        if (hold_chk && !(out_psel && out_penable && out_paddr == prev_addr)) hold_viol <= hold_viol + 1;
    end

    int ncmp = 0, nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apb(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int n);
        @(negedge clock);
        in_psel = 1'b1; in_penable = 1'b0; in_paddr = a; in_pwrite = w; in_pwdata = wd; in_pstrb = 4'hf;
        @(negedge clock);
        in_penable = 1'b1; n = 1;
        #1;
        while (!in_pready && n < 200) begin @(negedge clock); n++; end
        chk("apb_done", {31'b0, in_pready}, 32'd1);
        rd = in_prdata; er = in_pslverr;
        @(negedge clock);
        in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          n, x0, s0, c0, w0, cyc, stall_ok;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[4]  = 8'h11; mem[5]  = 8'h22; mem[6]  = 8'h33; mem[7]  = 8'h44;
        mem[8]  = 8'h55; mem[9]  = 8'h66; mem[10] = 8'h77; mem[11] = 8'h88;
        mem[16] = 8'hA0; mem[17] = 8'hB0; mem[18] = 8'hC0; mem[19] = 8'hD0;
        mem[20] = 8'h01; mem[21] = 8'h02; mem[22] = 8'h03; mem[23] = 8'h04;
        mem[60] = 8'hDE; mem[61] = 8'hAD; mem[62] = 8'hBE; mem[63] = 8'hEF;
        dn_ready = 1'b1; err_addr = 32'hFFFF_FFFF; go_until = 0;
        reset = 1'b1; in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
        in_paddr = '0; in_pwdata = '0; in_pstrb = '0;

        repeat (2) @(negedge clock);
        chk("rst_out", {out_paddr[27:0], out_psel, out_penable, out_pwrite, in_pready}, 32'h0);
        chk("rst_in", {in_prdata[30:0], in_pslverr}, 32'h0);
        chk("rst_state", 32'(dut.state_q), 32'(S_IDLE));
        reset = 1'b0;

        // basic XIP read, single poll
        go_until = ctrl_rd; x0 = xfers;
        apb(32'h3000_0004, 1'b0, '0, rd, er, n);
        chk("rd4_data", rd, 32'h4433_2211);
        chk("rd4_err", {31'b0, er}, 32'h0);
        chk("rd4_lat", n, 15);
        chk("rd4_xfers", xfers - x0, 7);
        chk("rd4_tx1", tx1_q, 32'h0300_0004);
        chk("rd4_ctrl", ctrl_v, 32'h0000_2540);
        chk("rd4_div", div_v, 32'h0000_0001);
        chk("rd4_ssclr", ss_last, 32'h0);

        // XIP write rejected without touching the SPI master
        s0 = setups;
        apb(32'h3000_0000, 1'b1, 32'h1234_5678, rd, er, n);
        chk("xw_err", {31'b0, er}, 32'd1);
        chk("xw_lat", n, 1);
        chk("xw_nosel", setups - s0, 0);

        // pass-through and window edges
        apb(32'h1000_1010, 1'b0, '0, rd, er, n);
        chk("pt_data", rd, 32'hCEAD_AEFF);
        chk("pt_addr", last_paddr, 32'h1000_1010);
        chk("pt_lat", n, 1);
        apb(32'h2FFF_FFFC, 1'b0, '0, rd, er, n);
        chk("below_win", rd, 32'hF152_4113);
        apb(32'h4000_0000, 1'b0, '0, rd, er, n);
        chk("above_win", rd, 32'h9EAD_BEEF);
        apb(32'h3FFF_FFFC, 1'b0, '0, rd, er, n);
        chk("top_data", rd, 32'hEFBE_ADDE);
        chk("top_tx1", tx1_q, 32'h03FF_FFFC);

        // POLL stalled 5 cycles, GO seen twice
        c0 = ctrl_rd; go_until = ctrl_rd + 2; stall_ok = 0; cyc = 0;
        fork
            apb(32'h3000_0014, 1'b0, '0, rd, er, n);
            begin
                while (!(out_psel && out_penable && !out_pwrite && out_paddr == 32'h10) && cyc < 100) begin
                    @(negedge clock); cyc++;
                end
                dn_ready = 1'b0;
                repeat (5) begin
                    @(negedge clock);
                    if (out_psel && out_penable && out_paddr == 32'h10) stall_ok++;
                end
                dn_ready = 1'b1;
            end
        join
        chk("poll_seen", {31'b0, cyc < 100}, 32'd1);
        chk("poll_hold", stall_ok, 5);
        chk("poll_reads", ctrl_rd - c0, 3);
        chk("poll_data", rd, 32'h0403_0201);
        chk("hold_viol", hold_viol, 0);

        // slave error on DIV: skip to SS clear, report error with zero data
        err_addr = 32'h14; w0 = ctrl_wr; s0 = ss_wr;
        apb(32'h3000_0018, 1'b0, '0, rd, er, n);
        err_addr = 32'hFFFF_FFFF;
        chk("err_flag", {31'b0, er}, 32'd1);
        chk("err_data", rd, 32'h0);
        chk("err_noctrl", ctrl_wr - w0, 0);
        chk("err_ssclr", ss_wr - s0, 1);

        // reset while polling
        go_until = ctrl_rd + 1000; cyc = 0;
        @(negedge clock);
        in_psel = 1'b1; in_penable = 1'b0; in_paddr = 32'h3000_0008; in_pwrite = 1'b0;
        @(negedge clock);
        in_penable = 1'b1;
        while (!(out_psel && out_penable && !out_pwrite && out_paddr == 32'h10) && cyc < 100) begin
            @(negedge clock); cyc++;
        end
        chk("rstp_seen", {31'b0, cyc < 100}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("rstp_out", {out_paddr[27:0], out_psel, out_penable, out_pwrite, in_pready}, 32'h0);
        chk("rstp_data", {in_prdata[30:0], in_pslverr}, 32'h0);
        chk("rstp_state", 32'(dut.state_q), 32'(S_IDLE));
        reset = 1'b0; in_psel = 1'b0; in_penable = 1'b0; go_until = ctrl_rd;
        apb(32'h3000_0008, 1'b0, '0, rd, er, n);
        chk("rstp_rd", rd, 32'h8877_6655);

`ifdef SPI_XIP_LINEBUF_EN
        x0 = xfers;
        apb(32'h3000_0010, 1'b0, '0, rd, er, n);
        chk("lb_fill", rd, 32'hD0C0_B0A0);
        x0 = xfers;
        apb(32'h3000_0010, 1'b0, '0, rd, er, n);
        chk("lb_hit_data", rd, 32'hD0C0_B0A0);
        chk("lb_hit_lat", n, 1);
        chk("lb_hit_noxfer", xfers - x0, 0);
        apb(32'h1000_1018, 1'b1, 32'h0, rd, er, n);
        x0 = xfers;
        apb(32'h3000_0010, 1'b0, '0, rd, er, n);
        chk("lb_inval_xfers", xfers - x0, 7);
        chk("lb_inval_data", rd, 32'hD0C0_B0A0);
`else
        for (int k = 0; k < 2; k++) begin
            x0 = xfers;
            apb(32'h3000_0010, 1'b0, '0, rd, er, n);
            chk("nolb_data", rd, 32'hD0C0_B0A0);
            chk("nolb_xfers", xfers - x0, 7);
        end
`endif
        chk("strb_bad", strb_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
